// File: rtl/mips_run_controller_if.sv
// mips_run_controller_if
//   Groups the two valid/ready streams of the run controller:
//     load stream : load_valid/load_ready/load_data/load_last (host -> controller)
//     dump stream : dump_valid/dump_ready/dump_data/dump_src/dump_last
//                   (controller -> sink)
//   Handshake rule for both streams: a word transfers on a rising clock edge
//   where valid and ready are both high. Once the producer raises valid, it holds
//   the valid and the payload stable until that edge. Ready may change freely.
//   The consumer ignores the payload while valid is low.
//   modport slave  : the controller side
//   modport master : the host / sink side
interface mips_run_controller_if #(
  parameter int DATA_WIDTH = 32
);
  logic                  load_valid;
  logic                  load_ready;
  logic [DATA_WIDTH-1:0] load_data;
  logic                  load_last;

  logic                  dump_valid;
  logic                  dump_ready;
  logic [DATA_WIDTH-1:0] dump_data;
  logic [1:0]            dump_src;
  logic                  dump_last;

  modport slave (
    input  load_valid, load_data, load_last, dump_ready,
    output load_ready, dump_valid, dump_data, dump_src, dump_last
  );

  modport master (
    output load_valid, load_data, load_last, dump_ready,
    input  load_ready, dump_valid, dump_data, dump_src, dump_last
  );
endinterface

// File: rtl/mips_run_controller.sv
// mips_run_controller
//   Sequences a test of the single-cycle MIPS core in three phases:
//     1. Load the instruction memory from the load stream. The core is held stalled.
//     2. Run the core (cpu_run high) for run_cycles clocks.
//     3. Dump the register file and then the data memory on the dump stream.
//   Ports:
//     clock, reset_n         rising-edge clock, asynchronous active-low reset
//     start, run_cycles      start pulse (IDLE/DONE only), cycle count sampled on start
//     bus (slave)            load stream and dump stream (see mips_run_controller_if)
//     imem_we/addr/wdata     registered instruction memory write port
//     cpu_run                core clock enable
//     reg_rd_addr/data       register file debug read port (1-cycle read latency)
//     dmem_rd_addr/data      data memory debug read port (1-cycle read latency)
//     busy, done             status outputs
//     dbg_state              current FSM state encoding
//   Optional feature: define DUMP_TRAILER_EN to append a trailer word
//   (dump_src = 2). The trailer carries {loaded words, executed cycles}.
module mips_run_controller #(
  parameter int DATA_WIDTH = 32,
  parameter int IMEM_DEPTH = 256,
  parameter int REG_COUNT  = 32,
  parameter int DMEM_DEPTH = 256,
  parameter int CYC_W      = 16
) (
  input  logic                          clock,
  input  logic                          reset_n,
  input  logic                          start,
  input  logic [CYC_W-1:0]              run_cycles,
  mips_run_controller_if.slave          bus,
  output logic                          imem_we,
  output logic [$clog2(IMEM_DEPTH)-1:0] imem_addr,
  output logic [DATA_WIDTH-1:0]         imem_wdata,
  output logic                          cpu_run,
  output logic [$clog2(REG_COUNT)-1:0]  reg_rd_addr,
  input  logic [DATA_WIDTH-1:0]         reg_rd_data,
  output logic [$clog2(DMEM_DEPTH)-1:0] dmem_rd_addr,
  input  logic [DATA_WIDTH-1:0]         dmem_rd_data,
  output logic                          busy,
  output logic                          done,
  output logic [2:0]                    dbg_state
);
  localparam int IMEM_AW = $clog2(IMEM_DEPTH);
  localparam int WA_W    = IMEM_AW + 1;  // wide enough to hold IMEM_DEPTH itself
  localparam int RAW     = $clog2(REG_COUNT);
  localparam int DAW     = $clog2(DMEM_DEPTH);
  localparam int IDX_W   = (DAW > RAW) ? DAW : RAW;

  localparam logic [1:0] SRC_REG = 2'd0;
  localparam logic [1:0] SRC_MEM = 2'd1;
`ifdef DUMP_TRAILER_EN
  localparam logic [1:0] SRC_TRL = 2'd2;
  localparam int         HW      = DATA_WIDTH / 2;
`endif

  typedef enum logic [2:0] {
    st_idle     = 3'd0,
    st_load     = 3'd1,
    st_run      = 3'd2,
    st_rd_issue = 3'd3,
    st_rd_hold  = 3'd4,
    st_done     = 3'd5
  } state_t;

  state_t                  state, state_n;
  logic [WA_W-1:0]         wr_cnt;
  logic [CYC_W-1:0]        cyc_cnt;
  logic [1:0]              src, src_n;
  logic [IDX_W-1:0]        idx, idx_n, rd_idx;
  logic [DATA_WIDTH-1:0]   dump_data_q, cap_data;
  logic [1:0]              dump_src_q;
  logic                    dump_last_q, cap_last;
  logic                    load_ready_c, dump_valid_c, load_hs, dump_hs;
`ifdef DUMP_TRAILER_EN
  logic [CYC_W-1:0]        exec_cnt;
`endif

  assign load_hs = load_ready_c & bus.load_valid;
  assign dump_hs = dump_valid_c & bus.dump_ready;

  // Next dump position: registers wrap into memory (and memory into the trailer).
  always_comb begin
    src_n = src;
    idx_n = idx + IDX_W'(1);
    if (src == SRC_REG && idx == IDX_W'(REG_COUNT - 1)) begin
      src_n = SRC_MEM;
      idx_n = '0;
    end
`ifdef DUMP_TRAILER_EN
    else if (src == SRC_MEM && idx == IDX_W'(DMEM_DEPTH - 1)) begin
      src_n = SRC_TRL;
      idx_n = '0;
    end
`endif
  end

  // The debug reads have one cycle of latency. The read address must already
  // point at the next word during the handshake cycle. That way the data is
  // ready to capture when RD_ISSUE ends.
  assign rd_idx       = dump_hs ? idx_n : idx;
  assign reg_rd_addr  = rd_idx[RAW-1:0];
  assign dmem_rd_addr = rd_idx[DAW-1:0];

  always_comb begin
    cap_data = (src == SRC_MEM) ? dmem_rd_data : reg_rd_data;
`ifdef DUMP_TRAILER_EN
    if (src == SRC_TRL) cap_data = {HW'(wr_cnt), HW'(exec_cnt)};
    cap_last = (src == SRC_TRL);
`else
    cap_last = (src == SRC_MEM) && (idx == IDX_W'(DMEM_DEPTH - 1));
`endif
  end

  // FSM state register
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) state <= st_idle;
    else          state <= state_n;
  end

  // FSM next state and decoded outputs
  always_comb begin
    state_n      = state;
    load_ready_c = 1'b0;
    cpu_run      = 1'b0;
    dump_valid_c = 1'b0;
    busy         = 1'b1;
    done         = 1'b0;
    case (state)
      st_idle, st_done: begin
        busy = 1'b0;
        done = (state == st_done);
        if (start) state_n = st_load;
      end
      st_load: begin
        load_ready_c = (wr_cnt < WA_W'(IMEM_DEPTH));
        if (load_hs && (bus.load_last || wr_cnt == WA_W'(IMEM_DEPTH - 1)))
          state_n = (cyc_cnt != '0) ? st_run : st_rd_issue;
      end
      st_run: begin
        cpu_run = 1'b1;
        if (cyc_cnt <= CYC_W'(1)) state_n = st_rd_issue;
      end
      st_rd_issue: state_n = st_rd_hold;
      st_rd_hold: begin
        dump_valid_c = 1'b1;
        if (bus.dump_ready) state_n = dump_last_q ? st_done : st_rd_issue;
      end
      default: state_n = st_idle;
    endcase
  end

  // Datapath: counters, imem write port, dump word registers
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_cnt      <= '0;
      cyc_cnt     <= '0;
      src         <= SRC_REG;
      idx         <= '0;
      imem_we     <= 1'b0;
      imem_addr   <= '0;
      imem_wdata  <= '0;
      dump_data_q <= '0;
      dump_src_q  <= '0;
      dump_last_q <= 1'b0;
`ifdef DUMP_TRAILER_EN
      exec_cnt    <= '0;
`endif
    end else begin
      imem_we <= 1'b0;
      case (state)
        st_idle, st_done: begin
          if (start) begin
            wr_cnt  <= '0;
            cyc_cnt <= run_cycles;
            src     <= SRC_REG;
            idx     <= '0;
`ifdef DUMP_TRAILER_EN
            exec_cnt <= '0;
`endif
          end
        end
        st_load: begin
          if (load_hs) begin
            imem_we    <= 1'b1;
            imem_addr  <= wr_cnt[IMEM_AW-1:0];
            imem_wdata <= bus.load_data;
            wr_cnt     <= wr_cnt + WA_W'(1);
          end
        end
        st_run: begin
          cyc_cnt <= cyc_cnt - CYC_W'(1);
`ifdef DUMP_TRAILER_EN
          exec_cnt <= exec_cnt + CYC_W'(1);
`endif
        end
        st_rd_issue: begin
          dump_data_q <= cap_data;
          dump_src_q  <= src;
          dump_last_q <= cap_last;
        end
        st_rd_hold: begin
          if (bus.dump_ready) begin
            src <= src_n;
            idx <= idx_n;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.load_ready = load_ready_c;
  assign bus.dump_valid = dump_valid_c;
  assign bus.dump_data  = dump_data_q;
  assign bus.dump_src   = dump_src_q;
  assign bus.dump_last  = dump_last_q;
  assign dbg_state      = state;
endmodule

// File: tb/tb_mips_run_controller.sv
module tb_mips_run_controller;
  localparam int DW = 32, IMEM_DEPTH = 256, REG_COUNT = 32, DMEM_DEPTH = 256, CYC_W = 16;
`ifdef DUMP_TRAILER_EN
  localparam bit TRAILER = 1'b1;
`else
  localparam bit TRAILER = 1'b0;
`endif

  // ---------------- clock / reset / DUT ----------------
  logic             clock = 1'b0;
  logic             reset_n = 1'b0;
  logic             start = 1'b0;
  logic [CYC_W-1:0] run_cycles = '0;
  logic             imem_we, cpu_run, busy, done;
  logic [7:0]       imem_addr, dmem_rd_addr;
  logic [4:0]       reg_rd_addr;
  logic [DW-1:0]    imem_wdata, reg_rd_data, dmem_rd_data;
  logic [2:0]       dbg_state;

  always #5 clock = ~clock;

  mips_run_controller_if #(.DATA_WIDTH(DW)) bus ();

  mips_run_controller #(
    .DATA_WIDTH(DW), .IMEM_DEPTH(IMEM_DEPTH), .REG_COUNT(REG_COUNT),
    .DMEM_DEPTH(DMEM_DEPTH), .CYC_W(CYC_W)
  ) dut (
    .clock(clock), .reset_n(reset_n), .start(start), .run_cycles(run_cycles),
    .bus(bus), .imem_we(imem_we), .imem_addr(imem_addr), .imem_wdata(imem_wdata),
    .cpu_run(cpu_run), .reg_rd_addr(reg_rd_addr), .reg_rd_data(reg_rd_data),
    .dmem_rd_addr(dmem_rd_addr), .dmem_rd_data(dmem_rd_data),
    .busy(busy), .done(done), .dbg_state(dbg_state)
  );

  // Environment: register file and data memory with fixed contents, 1-cycle read
  function automatic logic [DW-1:0] reg_val(input int i);
    return 32'hA500_0000 + DW'(i);
  endfunction
  function automatic logic [DW-1:0] dmem_val(input int i);
    return 32'h5A00_0000 + DW'(i) * 32'h0001_0101;
  endfunction
  function automatic logic [DW-1:0] prog_val(input int i);
    case (i)
      0: return 32'h2008_0005;
      1: return 32'h2009_0003;
      2: return 32'h0109_5020;
      default: return 32'hC0DE_0000 + DW'(i);
    endcase
  endfunction

  always @(posedge clock) begin
    reg_rd_data  <= reg_val(int'(reg_rd_addr));
    dmem_rd_data <= dmem_val(int'(dmem_rd_addr));
  end

  // ---------------- scoreboard ----------------
  logic [39:0] exp_imem_q[$];  // {addr, data}
  logic [34:0] exp_dump_q[$];  // {src, last, data}
  int tests_run = 0, tests_failed = 0;
  int run_cnt = 0, dump_hs_cnt = 0, ready_mode = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: samples on the falling edge, pops expectations when the DUT presents output
  logic [39:0] mon_ie;
  logic [34:0] mon_cur, mon_held, mon_de;
  logic        mon_stall = 1'b0;
  always @(negedge clock) begin
    if (!reset_n) begin
      mon_stall = 1'b0;
    end else begin
      if (cpu_run) run_cnt++;
      if (imem_we) begin
        if (exp_imem_q.size() == 0) check("imem_unexpected_write", {imem_addr, imem_wdata}, 64'h0);
        else begin
          mon_ie = exp_imem_q.pop_front();
          check("imem_write", {imem_addr, imem_wdata}, mon_ie);
        end
      end
      mon_cur = {bus.dump_src, bus.dump_last, bus.dump_data};
      if (mon_stall && bus.dump_valid) check("dump_stable_while_stalled", mon_cur, mon_held);
      if (bus.dump_valid && bus.dump_ready) begin
        dump_hs_cnt++;
        if (exp_dump_q.size() == 0) check("dump_unexpected_word", mon_cur, 64'h0);
        else begin
          mon_de = exp_dump_q.pop_front();
          check("dump_word", mon_cur, mon_de);
        end
      end
      mon_stall = bus.dump_valid && !bus.dump_ready;
      mon_held  = mon_cur;
    end
  end

  // Sink driver: always ready, or toggling every 3 cycles
  int rdy_cnt = 0;
  initial begin
    bus.dump_ready = 1'b1;
    forever begin
      @(posedge clock); #1;
      if (ready_mode == 0) bus.dump_ready = 1'b1;
      else begin
        rdy_cnt++;
        if (rdy_cnt % 3 == 0) bus.dump_ready = ~bus.dump_ready;
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clock); #1;
  endtask

  task automatic push_dump_exp(input int words, input int cycles);
    logic [15:0] w16, c16;
    w16 = words[15:0];
    c16 = cycles[15:0];
    for (int i = 0; i < REG_COUNT; i++) exp_dump_q.push_back({2'd0, 1'b0, reg_val(i)});
    for (int i = 0; i < DMEM_DEPTH; i++)
      exp_dump_q.push_back({2'd1, (!TRAILER && i == DMEM_DEPTH - 1), dmem_val(i)});
    if (TRAILER) exp_dump_q.push_back({2'd2, 1'b1, w16, c16});
  endtask

  task automatic send_word(input logic [DW-1:0] data, input logic last, output bit acc);
    bus.load_valid = 1'b1;
    bus.load_data  = data;
    bus.load_last  = last;
    acc = 1'b0;
    for (int t = 0; t < 20 && !acc; t++) begin
      @(negedge clock);
      if (bus.load_ready) acc = 1'b1;
      @(posedge clock); #1;
    end
    bus.load_valid = 1'b0;
    bus.load_last  = 1'b0;
  endtask

  task automatic begin_seq(input int n, input int cycles, input int mode);
    bit acc;
    ready_mode = mode;
    run_cnt = 0;
    push_dump_exp((n < IMEM_DEPTH) ? n : IMEM_DEPTH, cycles);
    start = 1'b1;
    run_cycles = CYC_W'(cycles);
    tick();
    start = 1'b0;
    run_cycles = '1;  // must have been latched on start
    check("load_ready_after_start", bus.load_ready, 1);
    for (int i = 0; i < n; i++) begin
      if (i < IMEM_DEPTH) exp_imem_q.push_back({8'(i), prog_val(i)});
      send_word(prog_val(i), (i == n - 1), acc);
      if (i < IMEM_DEPTH) check("load_accept", acc, 1);
      else                check("load_past_depth_rejected", acc, 0);
    end
  endtask

  task automatic finish_seq(input int cycles);
    for (int t = 0; t < 4000 && !done; t++) tick();
    check("seq_done", done, 1);
    check("seq_busy_low", busy, 0);
    check("cpu_run_cycles", run_cnt, cycles);
    check("dump_queue_drained", exp_dump_q.size(), 0);
    check("imem_queue_drained", exp_imem_q.size(), 0);
  endtask

  // ---------------- test sequence ----------------
  int base;
  initial begin
    bus.load_valid = 1'b0;
    bus.load_data  = '0;
    bus.load_last  = 1'b0;
    repeat (3) tick();
    check("reset_load_ready", bus.load_ready, 0);
    check("reset_dump_valid", bus.dump_valid, 0);
    check("reset_cpu_run", cpu_run, 0);
    reset_n = 1'b1;
    tick();
    check("idle_outputs", {imem_we, imem_addr, imem_wdata, cpu_run, busy, done}, 0);
    check("idle_dump_port", {bus.load_ready, bus.dump_valid, bus.dump_last, bus.dump_src, bus.dump_data}, 0);
    check("idle_read_addrs", {reg_rd_addr, dmem_rd_addr}, 0);
    check("idle_state", dbg_state, 0);

    // Load 3 words, run 5 cycles, full dump with an always-ready sink
    begin_seq(3, 5, 0);
    finish_seq(5);

    // run_cycles = 0 with backpressure on the dump port
    begin_seq(3, 0, 1);
    finish_seq(0);

    // Start pulse during RUN is ignored
    begin_seq(2, 20, 0);
    tick(); tick();
    check("in_run_before_start", cpu_run, 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_ignored_cpu_run", cpu_run, 1);
    check("start_ignored_load_ready", bus.load_ready, 0);
    check("start_ignored_busy", busy, 1);
    finish_seq(20);

    // Overflow: 257 words offered, only 256 written
    begin_seq(IMEM_DEPTH + 1, 1, 0);
    finish_seq(1);

    // Reset in the middle of a dump, then a clean rerun from address 0
    begin_seq(3, 5, 0);
    base = dump_hs_cnt;
    for (int t = 0; t < 2000 && dump_hs_cnt < base + 10; t++) tick();
    check("dump_progress_before_reset", dump_hs_cnt >= base + 10, 1);
    @(negedge clock); #2;
    reset_n = 1'b0;
    #1;
    check("async_reset_dump_valid", bus.dump_valid, 0);
    check("async_reset_status", {busy, done, cpu_run, bus.load_ready}, 0);
    exp_dump_q.delete();
    exp_imem_q.delete();
    tick();
    reset_n = 1'b1;
    tick();
    begin_seq(3, 5, 0);
    finish_seq(5);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation did not finish, tests_failed=%0d", tests_failed);
    $fatal(1, "watchdog");
  end
endmodule
